mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
- Game controller for the whack-a-mole grid.
- Decides which mole pops up, and for how long, using a pseudo-random LFSR and tick timers.
- Detects player whacks and drives the per-mole appear/hit lines consumed by the mole renderers.
- Keeps score and miss counters for the HUD; sits between the debounced button block and the mole display instances.

Parameters:
- NUM_MOLES, 9: number of moles. Legal range 8..16.
- TICK_DIV, 250000: clk cycles per game tick (10 ms at 25 MHz).
- UP_TICKS, 100: ticks a mole stays up.
- HIT_TICKS, 30: ticks the hit colour is held after a successful whack.
- GAP_TICKS, 50: ticks with no mole up between rounds.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- enable  input  1  game running; low pauses into IDLE.
- btn  input  NUM_MOLES  single-cycle debounced press pulses, one per mole.
- appear  output  NUM_MOLES  one-hot or zero; the mole currently up.
- hit  output  NUM_MOLES  one-hot or zero; the mole currently showing hit.
- active_idx  output  4  index of the current or last selected mole.
- score  output  16  successful whacks, saturating at 16'hFFFF.
- misses  output  8  timeouts plus wrong whacks, saturating at 8'hFF.

Behaviour:
- All outputs are registered. Synchronous reset (rst=1 at a clk edge) forces:
  - state=IDLE, appear=0, hit=0, active_idx=0, score=0, misses=0, prescaler=0;
  - LFSR=LFSR_SEED; previous-index register=0.
- Reset asserted mid-operation has the same effect; it overrides all other inputs.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  - Advances every clk except during rst.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick=1 when prescaler==TICK_DIV-1, then wraps to 0.
  - Cleared to 0 on every state transition, so a state of D ticks lasts exactly D*TICK_DIV cycles.
  - Held at 0 in IDLE.
- Tick counter: cleared on state entry, increments on each tick; the state exits on the cycle where tick=1 and count==D-1.
- FSM states IDLE, GAP, UP, HIT.
  - IDLE: appear=0, hit=0. enable=1 -> GAP.
  - GAP: appear=0, hit=0. On expiry of GAP_TICKS:
    - r=LFSR[3:0]; idx = r if r<NUM_MOLES, else r-NUM_MOLES.
    - If idx equals the previous index, idx=(idx+1) mod NUM_MOLES.
    - Store idx in active_idx and in the previous-index register; -> UP.
  - UP: appear[active_idx]=1, starting the first cycle after the GAP->UP edge. Per cycle:
    - btn[active_idx]=1 -> HIT, score+1. This takes priority over timer expiry in the same cycle; that case counts a score, not a miss.
    - Any other btn bit set -> misses+1, once per cycle regardless of how many wrong bits are set; stay in UP.
    - If the correct and wrong buttons are pressed in the same cycle, only the hit is taken.
    - Timer expiry of UP_TICKS with no correct press -> misses+1, -> GAP.
  - HIT: appear=0, hit[active_idx]=1. btn ignored. Expiry of HIT_TICKS -> GAP.
- enable=0 in any non-IDLE state -> IDLE on the next edge.
  - appear and hit clear on that edge.
  - score, misses and active_idx are retained; an in-flight round is abandoned with no score or miss.
- appear and hit are never both nonzero. Each is at most one-hot.
- Saturation: score and misses hold at max and never wrap.
- btn pulses in IDLE, GAP and HIT have no effect.

Test Plan (TICK_DIV=4, UP_TICKS=5, HIT_TICKS=2, GAP_TICKS=3, NUM_MOLES=9):
- rst for 2 cycles, then enable=1 -> all outputs 0 during reset. Exactly 12 cycles in GAP, then appear one-hot at bit active_idx (<9), computed from the model LFSR with seed 16'hACE1.
- Pulse btn[active_idx] on the 5th cycle of UP -> next cycle appear=0, hit[active_idx]=1, score=1. hit is held 8 cycles, then GAP for 12 cycles.
- No press during UP -> appear held exactly 20 cycles, then misses=1, score unchanged, appear=0.
- Pulse a wrong btn bit, then the correct btn bit, in UP -> misses=1 after the wrong press and appear unchanged; score=1 after the correct press. The correct press landing on the expiry cycle gives score+1 and misses unchanged.
- Drop enable mid-UP -> appear=0 next cycle, counters retained. Assert rst mid-HIT -> all outputs and the LFSR return to reset values.
- Run 200 rounds with random presses -> active_idx never repeats back-to-back, always <9; appear/hit mutually exclusive and one-hot every cycle; score/misses match the scoreboard. Force score to 16'hFFFF and verify saturation.

Source files
------------

// File: rtl/mole_scheduler_if.sv
// Game-side bundle between the button/display fabric and mole_scheduler.
// master drives enable and button pulses; slave (the scheduler) drives display and HUD lines.
interface mole_scheduler_if #(
    parameter int unsigned NUM_MOLES = 9
);
    logic                 enable;
    logic [NUM_MOLES-1:0] btn;
    logic [NUM_MOLES-1:0] appear;
    logic [NUM_MOLES-1:0] hit;
    logic [3:0]           active_idx;
    logic [15:0]          score;
    logic [7:0]           misses;

    modport master (
        output enable, btn,
        input  appear, hit, active_idx, score, misses
    );

    modport slave (
        input  enable, btn,
        output appear, hit, active_idx, score, misses
    );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: LFSR-driven mole selection, tick-timed GAP/UP/HIT rounds,
// whack detection and saturating score/miss counters.
module mole_scheduler #(
    parameter int unsigned NUM_MOLES = 9,
    parameter int unsigned TICK_DIV  = 250000,
    parameter int unsigned UP_TICKS  = 100,
    parameter int unsigned HIT_TICKS = 30,
    parameter int unsigned GAP_TICKS = 50,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic             clk,
    input logic             rst,
    mole_scheduler_if.slave bus
);
    localparam int unsigned PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAX_TICKS = (UP_TICKS > HIT_TICKS)
                                        ? ((UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS)
                                        : ((HIT_TICKS > GAP_TICKS) ? HIT_TICKS : GAP_TICKS);
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        UP,
        HIT
    } state_t;

    state_t               state_q, state_d;
    logic [PRE_W-1:0]     prescaler_q;
    logic [CNT_W-1:0]     tick_cnt_q;
    logic [15:0]          lfsr_q;
    logic [3:0]           prev_idx_q;
    logic [3:0]           active_idx_q;
    logic [NUM_MOLES-1:0] appear_q;
    logic [NUM_MOLES-1:0] hit_q;
    logic [15:0]          score_q;
    logic [7:0]           misses_q;

    logic                 tick;
    logic                 expire;
    logic [CNT_W-1:0]     last_tick;
    logic                 lfsr_fb;
    logic [3:0]           rand_idx;
    logic [3:0]           next_idx;
    logic [3:0]           idx_sel;
    logic [NUM_MOLES-1:0] sel_mask;
    logic [NUM_MOLES-1:0] up_mask;
    logic                 correct_press;
    logic                 wrong_press;
    logic                 score_inc;
    logic [1:0]           miss_inc;
    logic [8:0]           miss_sum;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign tick    = (prescaler_q == PRE_W'(TICK_DIV - 1));

    always_comb begin
        last_tick = '0;
        case (state_q)
            GAP:     last_tick = CNT_W'(GAP_TICKS - 1);
            UP:      last_tick = CNT_W'(UP_TICKS - 1);
            HIT:     last_tick = CNT_W'(HIT_TICKS - 1);
            default: last_tick = '0;
        endcase
    end

    assign expire = tick && (tick_cnt_q == last_tick);

    // Fold the 4-bit random value into range, then step past the previous mole.
    always_comb begin
        rand_idx = lfsr_q[3:0];
        if (32'(lfsr_q[3:0]) >= NUM_MOLES) begin
            rand_idx = 4'(32'(lfsr_q[3:0]) - NUM_MOLES);
        end
        next_idx = rand_idx;
        if (rand_idx == prev_idx_q) begin
            next_idx = (32'(rand_idx) == NUM_MOLES - 1) ? 4'd0 : rand_idx + 4'd1;
        end
    end

    assign sel_mask      = NUM_MOLES'(1) << active_idx_q;
    assign idx_sel       = (state_q == UP) ? active_idx_q : next_idx;
    assign up_mask       = NUM_MOLES'(1) << idx_sel;
    assign correct_press = |(bus.btn & sel_mask);
    assign wrong_press   = |(bus.btn & ~sel_mask);

    always_comb begin
        state_d   = state_q;
        score_inc = 1'b0;
        miss_inc  = 2'd0;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = GAP;
                GAP: begin
                    if (expire) state_d = UP;
                end
                UP: begin
                    if (correct_press) begin
                        state_d   = HIT;
                        score_inc = 1'b1;
                    end else begin
                        // A wrong whack and a timeout in the same cycle are two separate misses.
                        miss_inc = {1'b0, wrong_press} + {1'b0, expire};
                        if (expire) state_d = GAP;
                    end
                end
                HIT: begin
                    if (expire) state_d = GAP;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign miss_sum = {1'b0, misses_q} + {7'b0, miss_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prescaler_q  <= '0;
            tick_cnt_q   <= '0;
            lfsr_q       <= LFSR_SEED;
            prev_idx_q   <= '0;
            active_idx_q <= '0;
            appear_q     <= '0;
            hit_q        <= '0;
            score_q      <= '0;
            misses_q     <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= {lfsr_q[14:0], lfsr_fb};

            if ((state_d != state_q) || (state_q == IDLE)) begin
                prescaler_q <= '0;
                tick_cnt_q  <= '0;
            end else if (tick) begin
                prescaler_q <= '0;
                tick_cnt_q  <= tick_cnt_q + 1'b1;
            end else begin
                prescaler_q <= prescaler_q + 1'b1;
            end

            if ((state_q == GAP) && (state_d == UP)) begin
                active_idx_q <= next_idx;
                prev_idx_q   <= next_idx;
            end

            appear_q <= (state_d == UP)  ? up_mask  : '0;
            hit_q    <= (state_d == HIT) ? sel_mask : '0;

            if (score_inc && (score_q != '1)) begin
                score_q <= score_q + 16'd1;
            end
            misses_q <= miss_sum[8] ? '1 : miss_sum[7:0];
        end
    end

    assign bus.appear     = appear_q;
    assign bus.hit        = hit_q;
    assign bus.active_idx = active_idx_q;
    assign bus.score      = score_q;
    assign bus.misses     = misses_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with small tick parameters; a reference LFSR model
// predicts each selected mole and a score/miss scoreboard tracks every round.
module tb_mole_scheduler;
    localparam int unsigned N = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mole_scheduler_if #(.NUM_MOLES(N)) bus ();

    mole_scheduler #(
        .NUM_MOLES(N),
        .TICK_DIV (4),
        .UP_TICKS (5),
        .HIT_TICKS(2),
        .GAP_TICKS(3),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          checks;
    int          errors;
    bit          noise_on;
    int          m_score;
    int          m_misses;
    logic [3:0]  m_prev;
    logic [3:0]  cur_idx;
    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_prev;

    // Reference LFSR; m_lfsr_prev holds the value that was current before the latest edge.
    always @(posedge clk) begin
        m_lfsr_prev <= m_lfsr;
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [N-1:0] onehot(input logic [3:0] i);
        return N'(1) << i;
    endfunction

    function automatic logic [3:0] exp_pick(input logic [15:0] l, input logic [3:0] prev);
        logic [3:0] r;
        r = l[3:0];
        if (r >= 4'd9) r = r - 4'd9;
        if (r == prev) r = (r == 4'd8) ? 4'd0 : r + 4'd1;
        return r;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic ok;
        @(negedge clk);
        if (!rst) begin
            ok = $onehot0(bus.appear) && $onehot0(bus.hit) && !((|bus.appear) && (|bus.hit))
                 && (bus.active_idx < 4'd9);
            chk("invariant", {31'b0, ok}, 32'd1);
        end
    endtask

    task automatic wait_appear(output int n);
        n = 0;
        while (bus.appear == '0 && n < 200) begin
            if (noise_on) bus.btn = N'($urandom) & N'($urandom);
            step();
            n++;
        end
        bus.btn = '0;
    endtask

    task automatic wait_hit(output int n);
        n = 0;
        while (bus.hit != '0 && n < 200) begin
            if (noise_on) bus.btn = N'($urandom) & N'($urandom);
            step();
            n++;
        end
        bus.btn = '0;
    endtask

    task automatic start_round(input string tag);
        logic [3:0] e;
        e = exp_pick(m_lfsr_prev, m_prev);
        chk({tag, "_idx"}, {28'b0, bus.active_idx}, {28'b0, e});
        chk({tag, "_appear"}, {23'b0, bus.appear}, {23'b0, onehot(e)});
        chk({tag, "_hit_clear"}, {23'b0, bus.hit}, 32'd0);
        m_prev  = e;
        cur_idx = e;
    endtask

    initial begin
        int         n;
        int         c;
        bit         hitd;
        logic [3:0] first_idx;
        logic [N-1:0] wr;

        checks   = 0;
        errors   = 0;
        noise_on = 1'b0;
        m_score  = 0;
        m_misses = 0;
        m_prev   = '0;
        rst      = 1'b1;
        bus.enable = 1'b0;
        bus.btn    = '0;

        step();
        step();
        chk("rst_appear", {23'b0, bus.appear}, 32'd0);
        chk("rst_hit", {23'b0, bus.hit}, 32'd0);
        chk("rst_idx", {28'b0, bus.active_idx}, 32'd0);
        chk("rst_score", {16'b0, bus.score}, 32'd0);
        chk("rst_misses", {24'b0, bus.misses}, 32'd0);

        rst = 1'b0;
        bus.enable = 1'b1;
        wait_appear(n);
        chk("first_gap_len", n, 32'd13);
        start_round("r1");
        first_idx = cur_idx;

        // Correct whack on the 5th UP cycle
        repeat (4) step();
        chk("up5_appear", {23'b0, bus.appear}, {23'b0, onehot(cur_idx)});
        bus.btn = onehot(cur_idx);
        step();
        bus.btn = '0;
        m_score = 1;
        chk("whack_appear", {23'b0, bus.appear}, 32'd0);
        chk("whack_hit", {23'b0, bus.hit}, {23'b0, onehot(cur_idx)});
        chk("whack_score", {16'b0, bus.score}, 32'd1);
        chk("whack_misses", {24'b0, bus.misses}, 32'd0);
        wait_hit(n);
        chk("hit_len", n, 32'd8);
        wait_appear(n);
        chk("gap_len_after_hit", n, 32'd12);
        start_round("r2");

        // No press: timeout
        n = 0;
        while (bus.appear != '0 && n < 200) begin
            step();
            n++;
        end
        m_misses = 1;
        chk("up_len", n, 32'd20);
        chk("timeout_misses", {24'b0, bus.misses}, 32'd1);
        chk("timeout_score", {16'b0, bus.score}, 32'd1);
        chk("timeout_hit", {23'b0, bus.hit}, 32'd0);
        wait_appear(n);
        chk("gap_len_after_timeout", n, 32'd12);
        start_round("r3");

        // Two wrong bits in one cycle, then correct+wrong together
        bus.btn = onehot((cur_idx + 4'd1) % 4'd9) | onehot((cur_idx + 4'd3) % 4'd9);
        step();
        bus.btn = '0;
        m_misses = 2;
        chk("wrong_misses", {24'b0, bus.misses}, 32'd2);
        chk("wrong_appear", {23'b0, bus.appear}, {23'b0, onehot(cur_idx)});
        chk("wrong_score", {16'b0, bus.score}, 32'd1);
        step();
        chk("wrong_once", {24'b0, bus.misses}, 32'd2);
        bus.btn = onehot(cur_idx) | onehot((cur_idx + 4'd1) % 4'd9);
        step();
        bus.btn = '0;
        m_score = 2;
        chk("both_score", {16'b0, bus.score}, 32'd2);
        chk("both_misses", {24'b0, bus.misses}, 32'd2);
        chk("both_hit", {23'b0, bus.hit}, {23'b0, onehot(cur_idx)});
        wait_hit(n);
        chk("hit_len2", n, 32'd8);
        wait_appear(n);
        chk("gap_len3", n, 32'd12);
        start_round("r4");

        // Correct press on the expiry cycle
        repeat (19) step();
        chk("up20_appear", {23'b0, bus.appear}, {23'b0, onehot(cur_idx)});
        bus.btn = onehot(cur_idx);
        step();
        bus.btn = '0;
        m_score = 3;
        chk("expiry_score", {16'b0, bus.score}, 32'd3);
        chk("expiry_misses", {24'b0, bus.misses}, 32'd2);
        chk("expiry_hit", {23'b0, bus.hit}, {23'b0, onehot(cur_idx)});
        wait_hit(n);
        chk("hit_len3", n, 32'd8);
        wait_appear(n);
        chk("gap_len4", n, 32'd12);
        start_round("r5");

        // Pause mid-UP
        repeat (3) step();
        bus.enable = 1'b0;
        step();
        chk("pause_appear", {23'b0, bus.appear}, 32'd0);
        chk("pause_hit", {23'b0, bus.hit}, 32'd0);
        chk("pause_score", {16'b0, bus.score}, 32'd3);
        chk("pause_misses", {24'b0, bus.misses}, 32'd2);
        chk("pause_idx", {28'b0, bus.active_idx}, {28'b0, cur_idx});
        repeat (5) step();
        chk("idle_appear", {23'b0, bus.appear}, 32'd0);
        bus.enable = 1'b1;
        wait_appear(n);
        chk("resume_gap_len", n, 32'd13);
        start_round("r6");

        // Reset during HIT
        bus.btn = onehot(cur_idx);
        step();
        bus.btn = '0;
        chk("pre_rst_score", {16'b0, bus.score}, 32'd4);
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_appear", {23'b0, bus.appear}, 32'd0);
        chk("mid_rst_hit", {23'b0, bus.hit}, 32'd0);
        chk("mid_rst_idx", {28'b0, bus.active_idx}, 32'd0);
        chk("mid_rst_score", {16'b0, bus.score}, 32'd0);
        chk("mid_rst_misses", {24'b0, bus.misses}, 32'd0);
        m_score  = 0;
        m_misses = 0;
        m_prev   = '0;
        step();
        rst = 1'b0;
        wait_appear(n);
        chk("reseed_gap_len", n, 32'd13);
        start_round("r7");
        chk("reseed_same_idx", {28'b0, cur_idx}, {28'b0, first_idx});

        // Random rounds with noise outside UP
        noise_on = 1'b1;
        for (int r = 0; r < 200; r++) begin
            c    = $urandom_range(1, 26);
            hitd = 1'b0;
            for (int k = 1; k <= 20 && !hitd; k++) begin
                wr = '0;
                if (k < 20 && $urandom_range(0, 7) == 0) wr = N'($urandom) & ~onehot(cur_idx);
                bus.btn = wr | ((k == c) ? onehot(cur_idx) : '0);
                step();
                if (k == c) begin
                    hitd    = 1'b1;
                    m_score = sat(m_score, 65535);
                end else begin
                    if (wr != '0) m_misses = sat(m_misses, 255);
                    if (k == 20)  m_misses = sat(m_misses, 255);
                end
            end
            bus.btn = '0;
            chk("rnd_score", {16'b0, bus.score}, m_score);
            chk("rnd_misses", {24'b0, bus.misses}, m_misses);
            if (hitd) begin
                chk("rnd_hit", {23'b0, bus.hit}, {23'b0, onehot(cur_idx)});
                wait_hit(n);
                chk("rnd_hit_len", n, 32'd8);
            end else begin
                chk("rnd_timeout_appear", {23'b0, bus.appear}, 32'd0);
            end
            wait_appear(n);
            chk("rnd_gap_len", n, 32'd12);
            start_round("rnd");
        end

        // Drive misses to saturation with wrong presses every UP cycle
        for (int r = 0; r < 13; r++) begin
            for (int k = 1; k <= 20; k++) begin
                bus.btn = (k < 20) ? ~onehot(cur_idx) : '0;
                step();
                m_misses = sat(m_misses, 255);
            end
            bus.btn = '0;
            chk("sat_misses_round", {24'b0, bus.misses}, m_misses);
            wait_appear(n);
            chk("sat_gap_len", n, 32'd12);
            start_round("sat");
        end
        chk("misses_saturated", {24'b0, bus.misses}, 32'hFF);

        // Score saturation
        force dut.score_q = 16'hFFFF;
        #1;
        release dut.score_q;
        chk("score_forced", {16'b0, bus.score}, 32'hFFFF);
        bus.btn = onehot(cur_idx);
        step();
        bus.btn = '0;
        chk("score_saturated", {16'b0, bus.score}, 32'hFFFF);
        chk("score_sat_hit", {23'b0, bus.hit}, {23'b0, onehot(cur_idx)});
        chk("score_sat_misses", {24'b0, bus.misses}, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
